// File: rtl/axis_fork_sink_pkg.sv
// axis_fork_sink_pkg
// Shared definitions for the fork-channel sink: end-of-frame marker value,
// frame FSM encoding, FIFO sizing and a modulo-3 pointer helper.
package axis_fork_sink_pkg;

  // Default word width of the fork; MARKER_WORD is the marker at that width.
  localparam int                  SINK_DW     = 64;
  localparam logic [SINK_DW-1:0]  MARKER_WORD = '1;

  localparam int         FIFO_DEPTH    = 3;
  localparam logic [1:0] FIFO_FULL_CNT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } sink_state_t;

  // Circular pointer over FIFO_DEPTH (=3) slots.
  function automatic logic [1:0] fifo_ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/axis_sink_fifo3.sv
// axis_sink_fifo3
// Three-entry FIFO of {data, is_marker} with a registered occupancy count
// and a registered full flag.  Exposes the head entry plus the marker bit
// of the entry directly behind it, which the sink uses for tlast lookahead.
//   clk, rst       : clock, synchronous active-high reset
//   push/push_*    : write strobe, word and marker flag (ignored when full)
//   pop            : remove head entry (ignored when empty)
//   full, count    : registered status
//   head_data/head_marker : head entry
//   next_marker    : marker flag of the second entry (valid when count >= 2)
module axis_sink_fifo3
  import axis_fork_sink_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_marker,
  input  logic                  pop,
  output logic                  full,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_marker,
  output logic                  next_marker
);

  logic [DATA_WIDTH-1:0] mem_data   [FIFO_DEPTH];
  logic                  mem_marker [FIFO_DEPTH];
  logic [1:0]            rd_ptr, wr_ptr, count_nx;
  logic                  do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && (count != 2'd0);

  always_comb begin
    count_nx = count;
    case ({do_push, do_pop})
      2'b10:   count_nx = count + 2'd1;
      2'b01:   count_nx = count - 2'd1;
      default: count_nx = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 2'd0;
      full   <= 1'b0;
      // Storage is cleared so the sink's data output reads zero out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i]   <= '0;
        mem_marker[i] <= 1'b0;
      end
    end else begin
      if (do_push) begin
        mem_data[wr_ptr]   <= push_data;
        mem_marker[wr_ptr] <= push_marker;
        wr_ptr             <= fifo_ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= fifo_ptr_inc(rd_ptr);
      count <= count_nx;
      full  <= (count_nx == FIFO_FULL_CNT);
    end
  end

  assign head_data   = mem_data[rd_ptr];
  assign head_marker = mem_marker[rd_ptr];
  assign next_marker = mem_marker[fifo_ptr_inc(rd_ptr)];

endmodule

// File: rtl/axis_fork_sink.sv
// axis_fork_sink
// Terminator for one fork output channel.  Buffers the word stream, strips
// the fork's end-of-frame marker (all-ones word with tlast), re-marks the
// last real data word with tlast and reports each completed frame.
//   clk, rst              : clock, synchronous active-high reset
//   s_axis_*              : word stream from the fork (tready is registered)
//   m_axis_*              : data stream to chip TX, tlast on last data word
//   frame_done            : one-cycle pulse per completed frame
//   frame_word_cnt        : data words in the last completed frame
//   busy                  : frame in progress or data buffered
//   err_bad_last          : sticky, tlast seen on a non-marker word
module axis_fork_sink
  import axis_fork_sink_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  frame_word_cnt,
  output logic                  busy,
  output logic                  err_bad_last
);

  localparam logic [DATA_WIDTH-1:0] MARKER  = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

  logic                  full, head_marker, next_marker;
  logic [1:0]            fcount;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  push, pop, in_marker, data_push, marker_pop, hs;
  logic [1:0]            dcnt;
  logic [CNT_WIDTH-1:0]  wcnt;
  sink_state_t           state, state_nx;

  assign s_axis_tready = !full;
  assign push          = s_axis_tvalid && !full;
  assign in_marker     = s_axis_tlast && (s_axis_tdata == MARKER);
  assign data_push     = push && !in_marker;

  axis_sink_fifo3 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_data   (s_axis_tdata),
    .push_marker (in_marker),
    .pop         (pop),
    .full        (full),
    .count       (fcount),
    .head_data   (head_data),
    .head_marker (head_marker),
    .next_marker (next_marker)
  );

  // A data word is only offered once its successor is buffered, so the
  // successor's marker flag tells us whether this word ends the frame.
  assign m_axis_tvalid = (fcount >= 2'd2) && !head_marker;
  assign m_axis_tdata  = head_data;
  assign m_axis_tlast  = m_axis_tvalid && next_marker;
  assign hs            = m_axis_tvalid && m_axis_tready;

  // Markers are dropped as soon as they reach the head.  The one exception
  // is the DONE cycle: a back-to-back empty frame's marker waits a cycle so
  // each frame gets its own frame_done pulse.
  assign marker_pop = (fcount != 2'd0) && head_marker && (state != DONE);
  assign pop        = hs || marker_pop;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (marker_pop)                    state_nx = DONE;
        // Data accepted during DONE is already buffered when we land here.
        else if (data_push || dcnt != 2'd0) state_nx = ACTIVE;
      end
      ACTIVE:  if (marker_pop) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Data entries currently buffered (markers excluded).
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt <= 2'd0;
    end else begin
      case ({data_push, hs})
        2'b10:   dcnt <= dcnt + 2'd1;
        2'b01:   dcnt <= dcnt - 2'd1;
        default: dcnt <= dcnt;
      endcase
    end
  end

  // A marker pop and a data handshake never coincide (single pop per cycle),
  // so clearing on marker_pop loses no words.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt           <= '0;
      frame_word_cnt <= '0;
      err_bad_last   <= 1'b0;
    end else begin
      if (marker_pop) begin
        wcnt           <= '0;
        frame_word_cnt <= wcnt;
      end else if (hs && wcnt != CNT_MAX) begin
        wcnt <= wcnt + 1'b1;
      end
      if (push && s_axis_tlast && !in_marker) err_bad_last <= 1'b1;
    end
  end

  assign frame_done = (state == DONE);
  assign busy       = (state == ACTIVE) || (dcnt != 2'd0);

endmodule

// File: tb/tb_axis_fork_sink.sv
module tb_axis_fork_sink;
  import axis_fork_sink_pkg::*;

  localparam int DW = 64;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tlast;
  logic          s_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          frame_done;
  logic [CW-1:0] frame_word_cnt;
  logic          busy;
  logic          err_bad_last;

  axis_fork_sink #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tvalid  (s_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .frame_done     (frame_done),
    .frame_word_cnt (frame_word_cnt),
    .busy           (busy),
    .err_bad_last   (err_bad_last)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frames are sequences of data words closed by a marker.
  // The last data word before each marker must come out with tlast; every
  // marker yields one frame_done carrying the frame's data-word count.
  typedef struct {
    logic [63:0] d;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  int          exp_cnt_q[$];
  logic        held_v = 1'b0;
  logic [63:0] held_d;
  int          frame_len = 0;
  bit          any_bad = 0;
  int          acc_words = 0;
  int          done_seen = 0;
  int          ncyc = 0;
  int          last_acc_cyc = 0;
  int          last_done_cyc = 0;
  bit          busy_seen = 0;
  bit          mval_seen = 0;
  int          rmode = 0;   // 0: ready high, 1: ready low, 2: random

  task automatic model_accept(input logic [63:0] d, input logic l);
    if (l && d == MARKER_WORD) begin
      if (held_v) exp_q.push_back('{d: held_d, l: 1'b1});
      held_v = 1'b0;
      exp_cnt_q.push_back(frame_len);
      frame_len = 0;
    end else begin
      if (held_v) exp_q.push_back('{d: held_d, l: 1'b0});
      held_d = d;
      held_v = 1'b1;
      frame_len++;
      if (l) any_bad = 1;
    end
  endtask

  always @(posedge clk) ncyc <= ncyc + 1;

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = 1'b0;
      default: m_axis_tready = ($urandom_range(0, 9) < 7);
    endcase
  end

  // Output monitor / scoreboard
  beat_t       mon_e;
  bit          stall_prev = 0;
  logic [63:0] stall_d;
  int          exp_c;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", m_axis_tvalid, 1);
        chk("stall_data", m_axis_tdata, stall_d);
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_d    = m_axis_tdata;
      if (busy) busy_seen = 1;
      if (m_axis_tvalid) mval_seen = 1;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) chk("extra_out", m_axis_tdata, 64'hdead);
        else begin
          mon_e = exp_q.pop_front();
          chk("out_data", m_axis_tdata, mon_e.d);
          chk("out_last", m_axis_tlast, mon_e.l);
        end
      end
      if (frame_done) begin
        done_seen++;
        last_done_cyc = ncyc;
        if (exp_cnt_q.size() == 0) chk("extra_done", frame_word_cnt, 64'hdead);
        else begin
          exp_c = exp_cnt_q.pop_front();
          chk("done_cnt", frame_word_cnt, 64'(exp_c));
        end
      end
    end
  end

  task automatic send(input logic [63:0] d, input logic l, input int gap);
    bit ok = 0;
    repeat (gap) begin @(posedge clk); #1; end
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        ok = 1;
        model_accept(d, l);
        acc_words++;
        last_acc_cyc = ncyc;
      end
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || exp_cnt_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk(tag, 64'(exp_q.size() + exp_cnt_q.size()), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  int          d0, a0, nlen;
  logic [63:0] rd;
  logic        rl;

  initial begin
    rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;

    // Reset values
    @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", s_axis_tready, 1);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_cnt", frame_word_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_bad_last, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", s_axis_tready, 1);
    @(posedge clk); #1;

    // 4-word frame
    d0 = done_seen;
    for (int i = 1; i <= 4; i++) send(64'(i), 1'b0, 0);
    send(MARKER_WORD, 1'b1, 0);
    wait_drain("f4_drain");
    chk("f4_dones", 64'(done_seen - d0), 1);
    chk("f4_cnt_hold", frame_word_cnt, 4);

    // Backpressure during an 8-word frame
    d0 = done_seen; a0 = acc_words;
    rmode = 1;
    fork
      begin
        for (int i = 0; i < 8; i++) send(64'h100 + 64'(i), 1'b0, 0);
        send(MARKER_WORD, 1'b1, 0);
      end
    join_none
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("bp_accepted", 64'(acc_words - a0), 3);
    chk("bp_s_tready", s_axis_tready, 0);
    rmode = 0;
    wait fork;
    wait_drain("bp_drain");
    chk("bp_dones", 64'(done_seen - d0), 1);
    chk("bp_cnt", frame_word_cnt, 8);

    // Empty frame
    d0 = done_seen; busy_seen = 0; mval_seen = 0;
    send(MARKER_WORD, 1'b1, 0);
    a0 = last_acc_cyc;
    wait_drain("empty_drain");
    chk("empty_dones", 64'(done_seen - d0), 1);
    chk("empty_latency", 64'(last_done_cyc - a0), 2);
    chk("empty_busy", busy_seen, 0);
    chk("empty_mvalid", mval_seen, 0);
    chk("empty_cnt", frame_word_cnt, 0);

    // Bad last, then an all-ones word without tlast (plain data)
    send(64'h5, 1'b1, 0);
    send(64'h6, 1'b0, 0);
    send(MARKER_WORD, 1'b1, 0);
    wait_drain("badl_drain");
    chk("badl_err", err_bad_last, 1);
    send(MARKER_WORD, 1'b0, 1);
    send(64'h7, 1'b0, 0);
    send(MARKER_WORD, 1'b1, 0);
    wait_drain("ones_drain");
    chk("ones_cnt", frame_word_cnt, 2);
    chk("ones_err", err_bad_last, 1);

    // Back-to-back frames
    d0 = done_seen;
    send(64'hA1, 1'b0, 0); send(64'hA2, 1'b0, 0); send(MARKER_WORD, 1'b1, 0);
    send(64'hB1, 1'b0, 0); send(64'hB2, 1'b0, 0); send(64'hB3, 1'b0, 0);
    send(MARKER_WORD, 1'b1, 0);
    wait_drain("b2b_drain");
    chk("b2b_dones", 64'(done_seen - d0), 2);
    chk("b2b_cnt", frame_word_cnt, 3);
    chk("b2b_err", err_bad_last, 1);

    // Reset mid-frame
    send(64'h11, 1'b0, 0); send(64'h22, 1'b0, 0); send(64'h33, 1'b0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_outq", 64'(exp_q.size()), 0);
    d0 = done_seen;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    held_v = 1'b0; frame_len = 0; any_bad = 0;
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_mvalid", m_axis_tvalid, 0);
    chk("mid_s_tready", s_axis_tready, 1);
    chk("mid_err_clr", err_bad_last, 0);
    repeat (4) @(negedge clk);
    chk("mid_no_done", 64'(done_seen - d0), 0);
    chk("mid_busy2", busy, 0);
    @(posedge clk); #1;
    send(64'h44, 1'b0, 0);
    send(MARKER_WORD, 1'b1, 0);
    wait_drain("post_rst_drain");
    chk("post_rst_cnt", frame_word_cnt, 1);

    // Randomized frames with random backpressure and input gaps
    d0 = done_seen;
    rmode = 2;
    for (int f = 0; f < 25; f++) begin
      nlen = $urandom_range(0, 6);
      for (int w = 0; w < nlen; w++) begin
        rd = {$urandom(), $urandom()};
        rl = 1'b0;
        if ($urandom_range(0, 7) == 0) begin
          rl = 1'b1; rd[0] = 1'b0;
        end else if ($urandom_range(0, 9) == 0) begin
          rd = MARKER_WORD;
        end
        send(rd, rl, $urandom_range(0, 2));
      end
      send(MARKER_WORD, 1'b1, $urandom_range(0, 2));
    end
    wait_drain("rand_drain");
    rmode = 0;
    chk("rand_dones", 64'(done_seen - d0), 25);
    chk("rand_err", err_bad_last, 64'(any_bad));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
